// File: rtl/rename_multi.sv
// rename_multi: WIDTH-lane register rename stage. Chained in-group map bypass,
// circular free list of FLD entries, FIFO of map checkpoints for one-cycle
// branch recovery, registered single-stage output with backpressure.
module rename_multi #(
   parameter int N_LOG      = 32,
   parameter int N_PHYS     = 64,
   parameter int WIDTH      = 2,
   parameter int N_CHECKPTS = 8,
   parameter int ROB_TAG_W  = 6,
   localparam int PW  = $clog2(N_PHYS),
   localparam int CW  = $clog2(N_CHECKPTS),
   localparam int FLD = N_PHYS - N_LOG,
   localparam int FW  = $clog2(FLD)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             dec_valid_i,
   output logic                             dec_ready_o,
   input  logic [WIDTH-1:0]                 dec_lane_valid_i,
   input  logic [WIDTH-1:0][4:0]            dec_rs1_i,
   input  logic [WIDTH-1:0][4:0]            dec_rs2_i,
   input  logic [WIDTH-1:0][4:0]            dec_rd_i,
   input  logic [WIDTH-1:0]                 dec_rs1_used_i,
   input  logic [WIDTH-1:0]                 dec_rs2_used_i,
   input  logic [WIDTH-1:0]                 dec_rd_used_i,
   input  logic [WIDTH-1:0]                 dec_is_branch_i,
   output logic                             ren_valid_o,
   input  logic                             ren_ready_i,
   output logic [WIDTH-1:0]                 ren_lane_valid_o,
   output logic [WIDTH-1:0][PW-1:0]         rs1_p_o,
   output logic [WIDTH-1:0][PW-1:0]         rs2_p_o,
   output logic [WIDTH-1:0][PW-1:0]         rd_new_p_o,
   output logic [WIDTH-1:0][PW-1:0]         rd_old_p_o,
   output logic [WIDTH-1:0][CW-1:0]         ckpt_id_o,
   output logic [WIDTH-1:0][ROB_TAG_W-1:0]  rob_tag_o,
   input  logic [WIDTH-1:0]                 commit_free_valid_i,
   input  logic [WIDTH-1:0][PW-1:0]         commit_free_preg_i,
   input  logic                             ckpt_release_i,
   input  logic                             recover_i,
   input  logic [CW-1:0]                    recover_ckpt_i
);

   // architectural state
   logic [PW-1:0]        r_map [N_LOG];
   logic [PW-1:0]        r_fl [FLD];
   logic [FW:0]          r_head, r_tail;
   logic [ROB_TAG_W-1:0] r_rob;
   logic [CW:0]          r_ck_head, r_ck_tail;
   logic [PW-1:0]        r_ck_map [N_CHECKPTS][N_LOG];
   logic [FW:0]          r_ck_fhead [N_CHECKPTS];
   logic [ROB_TAG_W-1:0] r_ck_rob [N_CHECKPTS];
   logic                 r_live;

   // output register
   logic                            r_out_vld;
   logic [WIDTH-1:0]                r_lv;
   logic [WIDTH-1:0][PW-1:0]        r_rs1, r_rs2, r_new, r_old;
   logic [WIDTH-1:0][CW-1:0]        r_ckid;
   logic [WIDTH-1:0][ROB_TAG_W-1:0] r_tag;

   // rename datapath
   logic [PW-1:0]                   w_chain [WIDTH+1][N_LOG];
   logic [FW:0]                     w_hd [WIDTH+1];
   logic [ROB_TAG_W-1:0]            w_rob [WIDTH+1];
   logic [WIDTH-1:0]                w_lv, w_alloc, w_br;
   logic [WIDTH-1:0][PW-1:0]        w_rs1, w_rs2, w_new, w_old;
   logic [WIDTH-1:0][CW-1:0]        w_ckid;
   logic [WIDTH-1:0][ROB_TAG_W-1:0] w_tag;
   logic                            w_has_br;
   logic [PW-1:0]                   w_ck_map [N_LOG];
   logic [FW:0]                     w_ck_fhead;
   logic [ROB_TAG_W-1:0]            w_ck_rob;
   logic [FW:0]                     w_tail_nxt;
   logic [WIDTH-1:0][FW-1:0]        w_fidx;
   logic [FW:0]                     w_free_cnt;
   logic [CW:0]                     w_ck_cnt, w_rec_tail;
   logic [CW-1:0]                   w_rec_dist;
   logic                            w_accept;

   assign w_free_cnt = r_tail - r_head;
   assign w_ck_cnt   = r_ck_tail - r_ck_head;
   // Recovered tail keeps its wrap bit by measuring the distance from the head.
   assign w_rec_dist = recover_ckpt_i - r_ck_head[CW-1:0];
   assign w_rec_tail = r_ck_head + {1'b0, w_rec_dist};

   // Only registered free count is used, so same-cycle frees are not allocatable.
   assign dec_ready_o = r_live && !recover_i
                        && (w_free_cnt >= (FW+1)'(WIDTH))
                        && (w_ck_cnt != (CW+1)'(N_CHECKPTS))
                        && (!r_out_vld || ren_ready_i);
   assign w_accept = dec_valid_i && dec_ready_o;

   // Lane-by-lane map chain: each lane sees older lanes' allocations (RAW/WAW).
   always_comb begin
      w_chain[0] = r_map;
      w_hd[0]    = r_head;
      w_rob[0]   = r_rob;
      w_has_br   = 1'b0;
      w_ck_map   = r_map;
      w_ck_fhead = r_head;
      w_ck_rob   = r_rob;
      for (int k = 0; k < WIDTH; k++) begin
         w_lv[k]      = dec_valid_i && dec_lane_valid_i[k];
         w_alloc[k]   = w_lv[k] && dec_rd_used_i[k] && (dec_rd_i[k] != 5'd0);
         w_br[k]      = w_lv[k] && dec_is_branch_i[k];
         w_chain[k+1] = w_chain[k];
         w_rs1[k]  = (w_lv[k] && dec_rs1_used_i[k]) ? w_chain[k][dec_rs1_i[k]] : '0;
         w_rs2[k]  = (w_lv[k] && dec_rs2_used_i[k]) ? w_chain[k][dec_rs2_i[k]] : '0;
         w_old[k]  = w_alloc[k] ? w_chain[k][dec_rd_i[k]] : '0;
         w_new[k]  = w_alloc[k] ? r_fl[w_hd[k][FW-1:0]] : '0;
         w_tag[k]  = w_lv[k] ? w_rob[k] : '0;
         w_ckid[k] = w_br[k] ? r_ck_tail[CW-1:0] : '0;
         if (w_alloc[k]) w_chain[k+1][dec_rd_i[k]] = r_fl[w_hd[k][FW-1:0]];
         w_hd[k+1]  = w_hd[k] + (FW+1)'(w_alloc[k]);
         w_rob[k+1] = w_rob[k] + ROB_TAG_W'(w_lv[k]);
         if (w_br[k]) begin
            w_has_br   = 1'b1;
            w_ck_map   = w_chain[k+1];
            w_ck_fhead = w_hd[k+1];
            w_ck_rob   = w_rob[k+1];
         end
      end
   end

   // Free-list push slots: commit lanes take consecutive tail positions.
   always_comb begin
      w_tail_nxt = r_tail;
      for (int k = 0; k < WIDTH; k++) begin
         w_fidx[k] = w_tail_nxt[FW-1:0];
         if (commit_free_valid_i[k]) w_tail_nxt = w_tail_nxt + (FW+1)'(1);
      end
   end

   // Map table, pointers and ROB counter; recovery overrides acceptance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_LOG; i++) r_map[i] <= PW'(i);
         r_head    <= '0;
         r_tail    <= (FW+1)'(FLD);
         r_rob     <= '0;
         r_ck_head <= '0;
         r_ck_tail <= '0;
         r_live    <= 1'b0;
      end else begin
         r_live <= 1'b1;
         r_tail <= w_tail_nxt;
         if (recover_i) begin
            for (int i = 0; i < N_LOG; i++) r_map[i] <= r_ck_map[recover_ckpt_i][i];
            r_head    <= r_ck_fhead[recover_ckpt_i];
            r_rob     <= r_ck_rob[recover_ckpt_i];
            r_ck_tail <= w_rec_tail;
         end else if (w_accept) begin
            for (int i = 0; i < N_LOG; i++) r_map[i] <= w_chain[WIDTH][i];
            r_head <= w_hd[WIDTH];
            r_rob  <= w_rob[WIDTH];
            if (w_has_br) r_ck_tail <= r_ck_tail + (CW+1)'(1);
         end
         if (ckpt_release_i) r_ck_head <= r_ck_head + (CW+1)'(1);
      end
   end

   // Free-list storage, preloaded with the PREGs beyond the logical set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FLD; i++) r_fl[i] <= PW'(N_LOG + i);
      end else begin
         for (int k = 0; k < WIDTH; k++)
            if (commit_free_valid_i[k]) r_fl[w_fidx[k]] <= commit_free_preg_i[k];
      end
   end

   // Checkpoint storage; contents are don't-care while not in the live window.
   always_ff @(posedge clk) begin
      if (w_accept && w_has_br) begin
         for (int i = 0; i < N_LOG; i++) r_ck_map[r_ck_tail[CW-1:0]][i] <= w_ck_map[i];
         r_ck_fhead[r_ck_tail[CW-1:0]] <= w_ck_fhead;
         r_ck_rob[r_ck_tail[CW-1:0]]   <= w_ck_rob;
      end
   end

   // Output register: load on accept, hold under backpressure, flush on recovery.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_vld <= 1'b0;
         r_lv      <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_new     <= '0;
         r_old     <= '0;
         r_ckid    <= '0;
         r_tag     <= '0;
      end else if (recover_i) begin
         r_out_vld <= 1'b0;
      end else if (w_accept) begin
         r_out_vld <= 1'b1;
         r_lv      <= w_lv;
         r_rs1     <= w_rs1;
         r_rs2     <= w_rs2;
         r_new     <= w_new;
         r_old     <= w_old;
         r_ckid    <= w_ckid;
         r_tag     <= w_tag;
      end else if (ren_ready_i) begin
         r_out_vld <= 1'b0;
      end
   end

   assign ren_valid_o      = r_out_vld;
   assign ren_lane_valid_o = r_lv;
   assign rs1_p_o          = r_rs1;
   assign rs2_p_o          = r_rs2;
   assign rd_new_p_o       = r_new;
   assign rd_old_p_o       = r_old;
   assign ckpt_id_o        = r_ckid;
   assign rob_tag_o        = r_tag;

endmodule

// File: tb/tb_rename_multi.sv
// Bench for rename_multi: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based behavioural model.
module tb_rename_multi;
   localparam int W = 2, NL = 32, NP = 64, NC = 8, TW = 6, PW = 6, CW = 3, FLD = 32;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic dv, dr, rv, rr, rel, rec;
   logic [W-1:0] lv, u1, u2, ud, br, rlv, fv;
   logic [W-1:0][4:0] rs1, rs2, rd;
   logic [W-1:0][PW-1:0] p1, p2, pn, po, fp;
   logic [W-1:0][CW-1:0] ck;
   logic [W-1:0][TW-1:0] tag;
   logic [CW-1:0] rid;

   rename_multi dut (
      .clk(clk), .rst_n(rst_n), .dec_valid_i(dv), .dec_ready_o(dr),
      .dec_lane_valid_i(lv), .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_rd_i(rd),
      .dec_rs1_used_i(u1), .dec_rs2_used_i(u2), .dec_rd_used_i(ud), .dec_is_branch_i(br),
      .ren_valid_o(rv), .ren_ready_i(rr), .ren_lane_valid_o(rlv),
      .rs1_p_o(p1), .rs2_p_o(p2), .rd_new_p_o(pn), .rd_old_p_o(po),
      .ckpt_id_o(ck), .rob_tag_o(tag),
      .commit_free_valid_i(fv), .commit_free_preg_i(fp),
      .ckpt_release_i(rel), .recover_i(rec), .recover_ckpt_i(rid));

   int checks = 0, errors = 0;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [NL-1:0][PW-1:0] m;
      int npop;
      int rob;
      int abs;
   } ck_t;

   logic [NL-1:0][PW-1:0] m_map;
   int   hist[$];      // every PREG ever placed on the free list, in order
   int   npop;         // how many of them have been handed out
   int   m_rob;
   int   ck_abs;       // absolute checkpoint sequence number of the next push
   ck_t  ckq[$];
   int   rec_j;
   logic smp_ready;

   logic                 e_vld;
   logic [W-1:0]         e_lv;
   logic [W-1:0][PW-1:0] e_rs1, e_rs2, e_new, e_old;
   logic [W-1:0][CW-1:0] e_ck;
   logic [W-1:0][TW-1:0] e_tag;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NL; i++) m_map[i] = PW'(i);
      hist.delete();
      for (int i = NL; i < NP; i++) hist.push_back(i);
      npop = 0; m_rob = 0; ck_abs = 0; ckq.delete();
      e_vld = 1'b0; e_lv = '0; e_rs1 = '0; e_rs2 = '0; e_new = '0; e_old = '0; e_ck = '0; e_tag = '0;
   endtask

   function automatic bit mready();
      return !rec && (hist.size() - npop >= W) && (ckq.size() < NC) && (!e_vld || rr);
   endfunction

   task automatic model_step();
      bit acc;
      int nt;
      ck_t c;
      acc = dv && mready();
      if (rec) e_vld = 1'b0;
      else if (acc) begin
         nt = m_rob;
         e_lv = '0; e_rs1 = '0; e_rs2 = '0; e_new = '0; e_old = '0; e_ck = '0; e_tag = '0;
         for (int k = 0; k < W; k++) begin
            if (lv[k]) begin
               e_lv[k] = 1'b1;
               e_tag[k] = TW'(nt);
               nt = (nt + 1) % (1 << TW);
               if (u1[k]) e_rs1[k] = m_map[rs1[k]];
               if (u2[k]) e_rs2[k] = m_map[rs2[k]];
               if (ud[k] && rd[k] != 5'd0) begin
                  e_old[k] = m_map[rd[k]];
                  e_new[k] = PW'(hist[npop]);
                  npop++;
                  m_map[rd[k]] = e_new[k];
               end
               if (br[k]) begin
                  c.m = m_map; c.npop = npop; c.rob = nt; c.abs = ck_abs;
                  ckq.push_back(c);
                  e_ck[k] = CW'(ck_abs % NC);
                  ck_abs++;
               end
            end
         end
         m_rob = nt;
         e_vld = 1'b1;
      end else if (rr) e_vld = 1'b0;
      for (int k = 0; k < W; k++) if (fv[k]) hist.push_back(int'(fp[k]));
      if (rec) begin
         c = ckq[rec_j];
         m_map = c.m; npop = c.npop; m_rob = c.rob; ck_abs = c.abs;
         while (ckq.size() > rec_j) void'(ckq.pop_back());
      end
      if (rel) void'(ckq.pop_front());
   endtask

   task automatic check_outputs();
      chk("ren_valid", longint'(rv), longint'(e_vld));
      if (e_vld) begin
         for (int k = 0; k < W; k++) begin
            chk($sformatf("lane_valid[%0d]", k), longint'(rlv[k]), longint'(e_lv[k]));
            chk($sformatf("rs1_p[%0d]", k), longint'(p1[k]), longint'(e_rs1[k]));
            chk($sformatf("rs2_p[%0d]", k), longint'(p2[k]), longint'(e_rs2[k]));
            chk($sformatf("rd_new_p[%0d]", k), longint'(pn[k]), longint'(e_new[k]));
            chk($sformatf("rd_old_p[%0d]", k), longint'(po[k]), longint'(e_old[k]));
            chk($sformatf("ckpt_id[%0d]", k), longint'(ck[k]), longint'(e_ck[k]));
            chk($sformatf("rob_tag[%0d]", k), longint'(tag[k]), longint'(e_tag[k]));
         end
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      dv = 1'b0; lv = '0; rs1 = '0; rs2 = '0; rd = '0; u1 = '0; u2 = '0; ud = '0; br = '0;
      rr = 1'b1; fv = '0; fp = '0; rel = 1'b0; rec = 1'b0; rid = '0; rec_j = 0;
   endtask

   // One clock: check ready against the model, advance the model, check outputs.
   task automatic cycle();
      assert ($countones(br & lv) <= 1) else $error("more than one branch in a group");
      #1;
      smp_ready = dr;
      chk("dec_ready", longint'(dr), longint'(mready()));
      model_step();
      @(posedge clk); #1;
      check_outputs();
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #3;
      chk("rst ren_valid", longint'(rv), 0);
      chk("rst dec_ready", longint'(dr), 0);
      chk("rst data zero", longint'(|{rlv, p1, p2, pn, po, ck, tag}), 0);
      model_reset();
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic rand_inputs();
      int minpop, room;
      idle();
      dv = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < W; k++) begin
         lv[k]  = ($urandom_range(0, 3) != 0);
         rs1[k] = 5'($urandom_range(0, 7));
         rs2[k] = 5'($urandom_range(0, 7));
         rd[k]  = 5'($urandom_range(0, 7));
         u1[k]  = 1'($urandom_range(0, 1));
         u2[k]  = 1'($urandom_range(0, 1));
         ud[k]  = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 6) == 0) br[$urandom_range(0, W-1)] = 1'b1;
      rr = ($urandom_range(0, 3) != 0);
      // never free more than can be held even if the oldest checkpoint is restored
      minpop = (ckq.size() > 0) ? ckq[0].npop : npop;
      room = FLD - (hist.size() - minpop);
      for (int k = 0; k < W; k++)
         if ($urandom_range(0, 9) < 3 && room > 0) begin
            fv[k] = 1'b1; fp[k] = PW'($urandom_range(1, NP-1)); room--;
         end
      if (ckq.size() > 0 && $urandom_range(0, 4) == 0) rel = 1'b1;
      if (ckq.size() > 0 && $urandom_range(0, 11) == 0) begin
         rec = 1'b1;
         rec_j = $urandom_range(0, ckq.size() - 1);
         if (rec_j == 0) rel = 1'b0;
         rid = CW'(ckq[rec_j].abs % NC);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // T1: single lane after reset
      do_reset();
      idle(); dv = 1; lv[0] = 1; rs1[0] = 1; rs2[0] = 2; rd[0] = 3; u1[0] = 1; u2[0] = 1; ud[0] = 1;
      cycle();
      chk("T1 rs1_p", longint'(p1[0]), 1);
      chk("T1 rs2_p", longint'(p2[0]), 2);
      chk("T1 rd_old_p", longint'(po[0]), 3);
      chk("T1 rd_new_p", longint'(pn[0]), 32);
      chk("T1 rob_tag", longint'(tag[0]), 0);
      idle(); cycle();

      // T2: in-group RAW and WAW
      do_reset();
      idle(); dv = 1; lv = '1; rd[0] = 5; ud[0] = 1; rs1[1] = 5; u1[1] = 1; rd[1] = 5; ud[1] = 1;
      cycle();
      chk("T2 L0 new", longint'(pn[0]), 32);
      chk("T2 L0 old", longint'(po[0]), 5);
      chk("T2 L1 rs1_p", longint'(p1[1]), 32);
      chk("T2 L1 old", longint'(po[1]), 32);
      chk("T2 L1 new", longint'(pn[1]), 33);
      chk("T2 tag0", longint'(tag[0]), 0);
      chk("T2 tag1", longint'(tag[1]), 1);

      // T3: rd=0 does not allocate
      do_reset();
      idle(); dv = 1; lv[0] = 1; rd[0] = 0; ud[0] = 1;
      cycle();
      chk("T3 x0 new", longint'(pn[0]), 0);
      idle(); dv = 1; lv[0] = 1; rd[0] = 4; ud[0] = 1;
      cycle();
      chk("T3 next alloc", longint'(pn[0]), 32);

      // T4: checkpoint and recovery
      do_reset();
      idle(); dv = 1; lv[0] = 1; br[0] = 1; rd[0] = 6; ud[0] = 1;
      cycle();
      chk("T4 ckpt_id", longint'(ck[0]), 0);
      chk("T4 br new", longint'(pn[0]), 32);
      idle(); dv = 1; lv[0] = 1; rd[0] = 7; ud[0] = 1;
      cycle();
      chk("T4 rd7 new", longint'(pn[0]), 33);
      chk("T4 rd7 tag", longint'(tag[0]), 1);
      idle(); rec = 1; rid = 0; rec_j = 0;
      cycle();
      chk("T4 flushed", longint'(rv), 0);
      idle(); dv = 1; lv[0] = 1; rs1[0] = 7; u1[0] = 1; rd[0] = 8; ud[0] = 1;
      cycle();
      chk("T4 map7 restored", longint'(p1[0]), 7);
      chk("T4 realloc", longint'(pn[0]), 33);
      chk("T4 tag resumes", longint'(tag[0]), 1);

      // T5: free-list exhaustion and commit refill
      do_reset();
      for (int g = 0; g < 15; g++) begin
         idle(); dv = 1; lv = '1; rd[0] = 1; rd[1] = 2; ud = '1;
         cycle();
      end
      idle(); dv = 1; lv[0] = 1; rd[0] = 3; ud[0] = 1;
      cycle();
      chk("T5 alloc 62", longint'(pn[0]), 62);
      idle(); dv = 1; lv = '1; rd[0] = 4; rd[1] = 5; ud = '1; fv[0] = 1; fp[0] = 40;
      cycle();
      chk("T5 stalled", longint'(smp_ready), 0);
      fv = '0; fp = '0;
      cycle();
      chk("T5 ready again", longint'(smp_ready), 1);
      chk("T5 head entry", longint'(pn[0]), 63);
      chk("T5 freed preg", longint'(pn[1]), 40);

      // T6: downstream stall holds outputs and map
      do_reset();
      idle(); dv = 1; lv[0] = 1; rd[0] = 9; ud[0] = 1;
      cycle();
      idle(); rr = 0; dv = 1; lv[0] = 1; rs1[0] = 9; u1[0] = 1; rd[0] = 10; ud[0] = 1;
      for (int s = 0; s < 3; s++) begin
         cycle();
         chk("T6 not ready", longint'(smp_ready), 0);
         chk("T6 held new", longint'(pn[0]), 32);
      end
      rr = 1;
      cycle();
      chk("T6 accepted", longint'(smp_ready), 1);
      chk("T6 rs1 sees 32", longint'(p1[0]), 32);
      chk("T6 new 33", longint'(pn[0]), 33);

      // randomized run against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rand_inputs();
         cycle();
      end

      // reset while a group sits in the output register
      idle(); dv = 1; lv = '1; rr = 0;
      cycle();
      do_reset();
      idle(); cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
